// File: rtl/regfile_pkg.sv
// Shared definitions for the register-file dump reader: default widths and
// the dump FSM state encoding.
package regfile_pkg;

   localparam int RF_ADDR_W = 5;
   localparam int RF_DATA_W = 32;
   localparam int NREGS     = 2 ** RF_ADDR_W;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_READ = 2'd1,
      ST_OUT  = 2'd2,
      ST_DONE = 2'd3
   } state_t;

endpackage

// File: rtl/dump_addr_counter.sv
// Address walker for the dump: loads the first/last address of the range,
// steps with natural wrap at 2**ADDR_W, and flags the final entry.
module dump_addr_counter #(
   parameter int ADDR_W = 5
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              load,
   input  logic              inc,
   input  logic [ADDR_W-1:0] first_addr,
   input  logic [ADDR_W-1:0] final_addr,
   output logic [ADDR_W-1:0] cur_addr,
   output logic [ADDR_W-1:0] next_addr,
   output logic              is_last
);

   logic [ADDR_W-1:0] last_addr;

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         cur_addr  <= '0;
         last_addr <= '0;
      end else if (load) begin
         cur_addr  <= first_addr;
         last_addr <= final_addr;
      end else if (inc) begin
         cur_addr  <= next_addr;
      end
   end

   // Truncation to ADDR_W bits gives the wrap from the top entry back to 0.
   assign next_addr = cur_addr + ADDR_W'(1);
   assign is_last   = (cur_addr == last_addr);

endmodule

// File: rtl/regfile_dump_reader.sv
// Streams a wrapping range of register-file entries as {address, value} pairs
// over a valid/ready handshake, using one asynchronous read port.
module regfile_dump_reader
   import regfile_pkg::*;
#(
   parameter int ADDR_W = RF_ADDR_W,
   parameter int DATA_W = RF_DATA_W
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              start,
   input  logic              abort,
   input  logic [ADDR_W-1:0] start_addr,
   input  logic [ADDR_W-1:0] end_addr,
   output logic [ADDR_W-1:0] rd_addr,
   input  logic [DATA_W-1:0] rd_data,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [ADDR_W-1:0] out_addr,
   output logic [DATA_W-1:0] out_data,
   output logic              busy,
   output logic              done
);

   // Handshake: an entry transfers on a cycle where out_valid && out_ready at
   // the rising edge; out_addr/out_data do not change while out_valid is high
   // and unaccepted, and out_valid never drops without a transfer or an abort.

   state_t            state;
   state_t            state_nx;
   logic              load;
   logic              inc;
   logic              xfer;
   logic [ADDR_W-1:0] cur_addr;
   logic [ADDR_W-1:0] next_addr;
   logic              is_last;

   dump_addr_counter #(.ADDR_W(ADDR_W)) u_addr_counter (
      .clk        (clk),
      .rst_n      (rst_n),
      .load       (load),
      .inc        (inc),
      .first_addr (start_addr),
      .final_addr (end_addr),
      .cur_addr   (cur_addr),
      .next_addr  (next_addr),
      .is_last    (is_last)
   );

   assign xfer = out_valid && out_ready;

   always_ff @(posedge clk) begin
      if (!rst_n) state <= ST_IDLE;
      else        state <= state_nx;
   end

   always_comb begin
      state_nx = state;
      load     = 1'b0;
      inc      = 1'b0;
      case (state)
         ST_IDLE: begin
            if (start) begin
               load     = 1'b1;
               state_nx = ST_READ;
            end
         end
         ST_READ: begin
            state_nx = abort ? ST_IDLE : ST_OUT;
         end
         ST_OUT: begin
            if (abort) begin
               state_nx = ST_IDLE;
            end else if (xfer) begin
               if (is_last) begin
                  state_nx = ST_DONE;
               end else begin
                  inc      = 1'b1;
                  state_nx = ST_READ;
               end
            end
         end
         ST_DONE: begin
            state_nx = ST_IDLE;
         end
         default: state_nx = ST_IDLE;
      endcase
   end

   // rd_addr is loaded on the edge that enters READ so it is stable for the
   // whole READ cycle; outside READ it simply keeps its last value.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         rd_addr   <= '0;
         out_addr  <= '0;
         out_data  <= '0;
         out_valid <= 1'b0;
         done      <= 1'b0;
      end else begin
         if (state == ST_IDLE && start) rd_addr <= start_addr;
         if (state == ST_OUT && !abort && xfer && !is_last) rd_addr <= next_addr;
         if (state == ST_READ && !abort) begin
            out_addr <= cur_addr;
            out_data <= rd_data;
         end
         out_valid <= (state_nx == ST_OUT);
         done      <= (state_nx == ST_DONE);
      end
   end

   assign busy = (state != ST_IDLE);

endmodule

// File: tb/tb_regfile_dump_reader.sv
// Bench for regfile_dump_reader: behavioural register file, queue-based
// expectation model and an independent handshake monitor.
module tb_regfile_dump_reader;

   localparam int AW = 5;
   localparam int DW = 32;
   localparam int NR = 32;

   logic          clk = 1'b0;
   logic          rst_n = 1'b0;
   logic          start = 1'b0;
   logic          abort = 1'b0;
   logic          out_ready = 1'b0;
   logic [AW-1:0] start_addr = '0;
   logic [AW-1:0] end_addr = '0;
   logic [AW-1:0] rd_addr;
   logic [AW-1:0] out_addr;
   logic [DW-1:0] rd_data;
   logic [DW-1:0] out_data;
   logic          out_valid;
   logic          busy;
   logic          done;

   logic [DW-1:0]    regs [NR];
   logic [AW+DW-1:0] exp_q [$];

   int n_checks = 0;
   int n_pass = 0;
   int cyc = 0;
   int hs_cnt = 0;
   int hs_limit = 0;
   int ready_mode = 0;
   int stall_cnt = 0;

   logic          prev_stall = 1'b0;
   logic          prev_abort = 1'b0;
   logic [AW-1:0] prev_addr = '0;
   logic [DW-1:0] prev_data = '0;

   regfile_dump_reader dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .start      (start),
      .abort      (abort),
      .start_addr (start_addr),
      .end_addr   (end_addr),
      .rd_addr    (rd_addr),
      .rd_data    (rd_data),
      .out_valid  (out_valid),
      .out_ready  (out_ready),
      .out_addr   (out_addr),
      .out_data   (out_data),
      .busy       (busy),
      .done       (done)
   );

   // Clock / reset and the behavioural register file
   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;
   assign rd_data = regs[rd_addr];

   task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
      n_checks++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got %0h expected %0h (t=%0t)", name, got, exp, $time);
   endtask

   // Consumer: 0 always ready, 1 random, 2 four stall cycles per entry,
   // 3 ready only until hs_limit entries have been taken.
   always @(posedge clk) begin
      #1;
      case (ready_mode)
         0: out_ready = 1'b1;
         1: out_ready = 1'($urandom_range(0, 1));
         2: begin
            if (out_valid) begin
               out_ready = (stall_cnt == 4);
               stall_cnt = (stall_cnt == 4) ? 0 : stall_cnt + 1;
            end else begin
               out_ready = 1'b0;
               stall_cnt = 0;
            end
         end
         default: out_ready = (hs_cnt < hs_limit);
      endcase
   end

   // Monitor / scoreboard
   always @(negedge clk) begin
      if (!rst_n) begin
         prev_stall = 1'b0;
      end else begin
         if (prev_stall && !prev_abort) begin
            check("stall_valid", 64'(out_valid), 64'd1);
            check("stall_addr", 64'(out_addr), 64'(prev_addr));
            check("stall_data", 64'(out_data), 64'(prev_data));
         end
         if (out_valid && out_ready) begin
            hs_cnt++;
            if (exp_q.size() == 0) check("unexpected_entry", 64'(exp_q.size()), 64'd1);
            else check("entry", 64'({out_addr, out_data}), 64'(exp_q.pop_front()));
         end
         prev_stall = out_valid && !out_ready;
         prev_abort = abort;
         prev_addr  = out_addr;
         prev_data  = out_data;
      end
   end

   // Full dump of [s..e] (wrapping); optional write to regs[s] at the edge ending READ.
   task automatic run_dump(input int s, input int e, input int mode,
                           input bit do_wr = 1'b0, input logic [DW-1:0] wr_d = '0);
      int n;
      int t0;
      bit seen;
      n = ((e - s + NR) % NR) + 1;
      for (int i = 0; i < n; i++) begin
         int a;
         a = (s + i) % NR;
         exp_q.push_back({AW'(a), regs[a]});
      end
      ready_mode = mode;
      @(posedge clk); #1;
      start_addr = AW'(s);
      end_addr   = AW'(e);
      start      = 1'b1;
      @(posedge clk); #1;
      t0         = cyc;
      start      = 1'b0;
      start_addr = AW'($urandom);
      end_addr   = AW'($urandom);
      if (do_wr) begin
         @(posedge clk);
         regs[s] <= wr_d;
      end
      seen = 1'b0;
      for (int k = 0; k < 3000 && !seen; k++) begin
         @(negedge clk);
         if (k == 0) check("busy_running", 64'(busy), 64'd1);
         start = (k == 2 && n >= 2);
         if (done) seen = 1'b1;
      end
      start = 1'b0;
      check("done_seen", 64'(seen), 64'd1);
      if (seen) begin
         if (mode == 0) check("done_cycle", 64'(cyc - t0), 64'(2 * n));
         check("queue_drained", 64'(exp_q.size()), 64'd0);
         start = 1'b1;
         @(posedge clk); #1;
         start = 1'b0;
         @(negedge clk);
         check("done_one_cycle", 64'(done), 64'd0);
         check("start_in_done_ignored", 64'(busy), 64'd0);
      end else begin
         exp_q.delete();
         rst_n = 1'b0;
         @(posedge clk); #1;
         rst_n = 1'b1;
      end
   endtask

   // Dump of [s..e] cut short by abort (use_rst=0) or reset after `keep` entries.
   task automatic run_cut(input int s, input int e, input int keep, input bit use_rst);
      bit reached;
      bit any_done;
      for (int i = 0; i < keep; i++) begin
         int a;
         a = (s + i) % NR;
         exp_q.push_back({AW'(a), regs[a]});
      end
      hs_limit   = hs_cnt + keep;
      ready_mode = 3;
      @(posedge clk); #1;
      start_addr = AW'(s);
      end_addr   = AW'(e);
      start      = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      reached = 1'b0;
      for (int k = 0; k < 200 && !reached; k++) begin
         @(negedge clk);
         if (out_valid && out_addr == AW'((s + keep) % NR)) reached = 1'b1;
      end
      check("cut_point_reached", 64'(reached), 64'd1);
      @(posedge clk); #1;
      if (use_rst) rst_n = 1'b0;
      else abort = 1'b1;
      @(posedge clk); #1;
      rst_n = 1'b1;
      abort = 1'b0;
      @(negedge clk);
      check("cut_busy", 64'(busy), 64'd0);
      check("cut_valid", 64'(out_valid), 64'd0);
      if (use_rst) begin
         check("rst_rd_addr", 64'(rd_addr), 64'd0);
         check("rst_out_addr", 64'(out_addr), 64'd0);
         check("rst_out_data", 64'(out_data), 64'd0);
      end
      any_done = done;
      repeat (6) begin
         @(negedge clk);
         any_done |= done;
      end
      check("cut_no_done", 64'(any_done), 64'd0);
      check("cut_queue_drained", 64'(exp_q.size()), 64'd0);
      exp_q.delete();
   endtask

   initial begin
      regs[0] = '0;
      for (int i = 1; i < NR; i++) regs[i] = 32'h1000_0000 + DW'(i);
      rst_n = 1'b0;
      repeat (3) @(posedge clk);
      #1 rst_n = 1'b1;
      @(negedge clk);
      check("reset_busy", 64'(busy), 64'd0);
      check("reset_valid", 64'(out_valid), 64'd0);
      check("reset_done", 64'(done), 64'd0);
      check("reset_rd_addr", 64'(rd_addr), 64'd0);
      check("reset_out_addr", 64'(out_addr), 64'd0);
      check("reset_out_data", 64'(out_data), 64'd0);

      run_dump(3, 5, 0);
      run_dump(30, 1, 0);
      run_dump(10, 13, 2);
      run_dump(7, 7, 0);
      run_dump(7, 6, 0);
      run_cut(10, 14, 1, 1'b0);
      run_cut(20, 25, 2, 1'b1);
      run_dump(20, 25, 0);
      run_dump(4, 4, 0, 1'b1, 32'hDEAD_BEEF);
      run_dump(2, 5, 0);

      for (int r = 0; r < 8; r++) begin
         regs[$urandom_range(1, NR - 1)] = $urandom;
         run_dump(int'($urandom_range(0, NR - 1)), int'($urandom_range(0, NR - 1)), 1);
      end

      check("final_queue_empty", 64'(exp_q.size()), 64'd0);
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
